// File: rtl/uart_burst_tx.sv
// Periodic UART burst transmitter with an integrated serializer.
// Every PERIOD_CYCLES clocks while en is high, sends MSG_LEN consecutive
// characters starting at START_CHAR. Frame format is set by DATA_BITS,
// PARITY (0 none, 1 odd, 2 even) and STOP_BITS.
// Optional build macro UART_BURST_CRLF_EN appends CR, LF to every burst.
module uart_burst_tx #(
    parameter int unsigned CLKS_PER_BIT  = 16,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1,
    parameter logic [7:0]  START_CHAR    = 8'h30,
    parameter int unsigned MSG_LEN       = 10,
    parameter int unsigned PERIOD_CYCLES = 8000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tx,
    output logic busy,
    output logic byte_done,
    output logic burst_done,
    output logic overrun
);

    localparam int unsigned CntW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned ClkW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_BURST_CRLF_EN
    localparam int unsigned NumFrames = MSG_LEN + 2;
    localparam logic [7:0]  CharCr    = 8'h0D;
    localparam logic [7:0]  CharLf    = 8'h0A;
`else
    localparam int unsigned NumFrames = MSG_LEN;
`endif

    localparam logic [8:0]      LastIdx = 9'(NumFrames - 1);
    localparam logic [CntW-1:0] PerMax  = CntW'(PERIOD_CYCLES - 1);
    localparam logic [ClkW-1:0] BitMax  = ClkW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      DataMax = 3'(DATA_BITS - 1);
    localparam logic [2:0]      StopMax = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // Period counter
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick;

    // Serializer state
    state_e               state_q, state_d;
    logic [ClkW-1:0]      clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [8:0]           idx_q, idx_d;
    logic                 bit_end;

    // Registered outputs
    logic tx_q, tx_d;
    logic busy_q, busy_d;
    logic byte_done_q, byte_done_d;
    logic burst_done_q, burst_done_d;
    logic overrun_q, overrun_d;

    // Character for the current frame index
    logic [7:0]           char_sum;
    logic [DATA_BITS-1:0] load_byte;

    // Period counter next state: held at zero while disabled, wraps at PERIOD_CYCLES-1
    always_comb begin
        tick  = en && (cnt_q == PerMax);
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == PerMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Period counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Select the character for frame idx_q, truncated to the frame width
    always_comb begin
        char_sum  = START_CHAR + idx_q[7:0];
        load_byte = char_sum[DATA_BITS-1:0];
`ifdef UART_BURST_CRLF_EN
        if (idx_q == 9'(MSG_LEN)) begin
            load_byte = CharCr[DATA_BITS-1:0];
        end else if (idx_q == 9'(MSG_LEN + 1)) begin
            load_byte = CharLf[DATA_BITS-1:0];
        end
`endif
    end

    // FSM next state: frame sequencing, bit timing and burst indexing
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        idx_d     = idx_q;
        bit_end   = (clk_cnt_q == BitMax);

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shreg_d   = load_byte;
                // Odd parity sets the bit when the data has an even ones count
                par_d     = (PARITY == 1) ? ~(^load_byte) : (^load_byte);
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shreg_d   = shreg_q >> 1;
                    if (bit_cnt_q == DataMax) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = StStop;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == StopMax) begin
                        bit_cnt_d = '0;
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            state_d = StIdle;
                        end else begin
                            idx_d   = idx_q + 9'd1;
                            state_d = StLoad;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next state, derived from the upcoming FSM state so outputs can be registered
    always_comb begin
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shreg_d[0];
            StParity: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d       = (state_d != StIdle);
        byte_done_d  = (state_d == StStop) && (clk_cnt_d == BitMax) && (bit_cnt_d == StopMax);
        burst_done_d = byte_done_d && (idx_d == LastIdx);
        overrun_d    = tick && (state_q != StIdle);
    end

    // FSM and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            idx_q        <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            byte_done_q  <= 1'b0;
            burst_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            idx_q        <= idx_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            byte_done_q  <= byte_done_d;
            burst_done_q <= burst_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign byte_done  = byte_done_q;
    assign burst_done = burst_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_burst_tx.sv
// Bench for uart_burst_tx: three configurations run side by side against a
// per-cycle waveform model built from frame rules, plus literal spot checks.
module tb_uart_burst_tx;

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    logic [2:0] en_v;
    logic [2:0] tx_w, busy_w, bd_w, brd_w, ov_w;

    int cyc_q = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_q <= cyc_q + 1;

    // Instance 0: defaults
    uart_burst_tx u0 (
        .clk(clk), .rst_n(rst_v[0]), .en(en_v[0]), .tx(tx_w[0]), .busy(busy_w[0]),
        .byte_done(bd_w[0]), .burst_done(brd_w[0]), .overrun(ov_w[0])
    );

    // Instance 1: short period, bursts overlap the period
    uart_burst_tx #(
        .PERIOD_CYCLES(1000)
    ) u1 (
        .clk(clk), .rst_n(rst_v[1]), .en(en_v[1]), .tx(tx_w[1]), .busy(busy_w[1]),
        .byte_done(bd_w[1]), .burst_done(brd_w[1]), .overrun(ov_w[1])
    );

    // Instance 2: 7E2 format with byte wrap
    uart_burst_tx #(
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .START_CHAR(8'h7E), .MSG_LEN(3),
        .PERIOD_CYCLES(600)
    ) u2 (
        .clk(clk), .rst_n(rst_v[2]), .en(en_v[2]), .tx(tx_w[2]), .busy(busy_w[2]),
        .byte_done(bd_w[2]), .burst_done(brd_w[2]), .overrun(ov_w[2])
    );

    function automatic int p_db(input int i);  return (i == 2) ? 7 : 8; endfunction
    function automatic int p_par(input int i); return (i == 2) ? 2 : 0; endfunction
    function automatic int p_sb(input int i);  return (i == 2) ? 2 : 1; endfunction
    function automatic int p_sc(input int i);  return (i == 2) ? 'h7E : 'h30; endfunction
    function automatic int p_ml(input int i);  return (i == 2) ? 3 : 10; endfunction
    function automatic int p_per(input int i);
        return (i == 0) ? 8000 : ((i == 1) ? 1000 : 600);
    endfunction
    localparam int Cpb = 16;

`ifdef UART_BURST_CRLF_EN
    localparam int Extra = 2;
`else
    localparam int Extra = 0;
`endif

    // Model state: expected waveform {burst_done, byte_done, busy, tx} per cycle
    logic [3:0] wave [3][4096];
    int         len [3];
    int         pos [3];
    int         run [3];
    logic       ov_exp [3];
    logic       mvalid [3];

    // Literal expectations
    int   lit_inst [64];
    int   lit_cyc  [64];
    int   lit_sig  [64];
    logic lit_val  [64];
    int   nlit = 0;

    task automatic add_lit(input int i, input int c, input int s, input logic v);
        lit_inst[nlit] = i;
        lit_cyc[nlit]  = c;
        lit_sig[nlit]  = s;
        lit_val[nlit]  = v;
        nlit++;
    endtask

    task automatic push_bit(input int i, inout int n, input logic v);
        for (int c = 0; c < Cpb; c++) begin
            wave[i][n] = {2'b00, 1'b1, v};
            n++;
        end
    endtask

    // Expected waveform of a whole burst, starting with the first LOAD cycle
    task automatic build_burst(input int i);
        int         n;
        int         nf;
        int         ones;
        logic [7:0] b;
        logic       pbit;
        n  = 0;
        nf = p_ml(i) + Extra;
        for (int f = 0; f < nf; f++) begin
            if (f < p_ml(i)) b = 8'((p_sc(i) + f) % 256);
            else             b = (f == p_ml(i)) ? 8'h0D : 8'h0A;
            b = b & 8'((1 << p_db(i)) - 1);
            wave[i][n] = 4'b0011;
            n++;
            push_bit(i, n, 1'b0);
            for (int k = 0; k < p_db(i); k++) push_bit(i, n, b[k]);
            ones = $countones(b);
            if (p_par(i) != 0) begin
                pbit = (p_par(i) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
                push_bit(i, n, pbit);
            end
            for (int s = 0; s < p_sb(i); s++) push_bit(i, n, 1'b1);
            wave[i][n-1][2] = 1'b1;
            if (f == nf - 1) wave[i][n-1][3] = 1'b1;
        end
        len[i] = n;
        pos[i] = 0;
    endtask

    task automatic chk(input string name, input int i, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %b, expected %b", name, i, cyc_q, got, want);
        end
    endtask

    function automatic logic get_sig(input int i, input int s);
        case (s)
            0:       return tx_w[i];
            1:       return busy_w[i];
            2:       return bd_w[i];
            3:       return brd_w[i];
            default: return ov_w[i];
        endcase
    endfunction

    // Compare process: checks every cycle at negedge, then advances the model
    initial begin
        logic [3:0] e;
        logic       cur_busy;
        logic       tick;
        for (int i = 0; i < 3; i++) begin
            len[i] = 0; pos[i] = 0; run[i] = 0; ov_exp[i] = 1'b0; mvalid[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                cur_busy = (pos[i] < len[i]);
                e = cur_busy ? wave[i][pos[i]] : 4'b0001;
                if (mvalid[i]) begin
                    chk("tx", i, tx_w[i], e[0]);
                    chk("busy", i, busy_w[i], e[1]);
                    chk("byte_done", i, bd_w[i], e[2]);
                    chk("burst_done", i, brd_w[i], e[3]);
                    chk("overrun", i, ov_w[i], ov_exp[i]);
                end
                for (int j = 0; j < nlit; j++) begin
                    if (lit_inst[j] == i && lit_cyc[j] == cyc_q) begin
                        chk("literal", i, get_sig(i, lit_sig[j]), lit_val[j]);
                    end
                end
                if (cur_busy) pos[i]++;
                if (!rst_v[i]) begin
                    len[i] = 0; pos[i] = 0; run[i] = 0; ov_exp[i] = 1'b0; mvalid[i] = 1'b1;
                end else begin
                    tick = en_v[i] && ((run[i] % p_per(i)) == p_per(i) - 1);
                    ov_exp[i] = tick && cur_busy;
                    if (tick && !cur_busy) build_burst(i);
                    run[i] = en_v[i] ? run[i] + 1 : 0;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc_q < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Signals: 0 tx, 1 busy, 2 byte_done, 3 burst_done, 4 overrun. en rises at cycle 4.
    initial begin
        rst_v = 3'b000;
        en_v  = 3'b000;
        // u0: tick 8003, LOAD 8004, start bit from 8005
        add_lit(0, 8003, 1, 1'b0);
        add_lit(0, 8004, 0, 1'b1);
        add_lit(0, 8004, 1, 1'b1);
        add_lit(0, 8005, 0, 1'b0);
        add_lit(0, 8021, 0, 1'b0);
        add_lit(0, 8085, 0, 1'b1);
        add_lit(0, 8164, 2, 1'b1);
        add_lit(0, 8165, 0, 1'b1);
        add_lit(0, 8182, 0, 1'b1);
        add_lit(0, 16704, 0, 1'b1);
        add_lit(0, 16704, 1, 1'b0);
        add_lit(0, 24704, 0, 1'b1);
        add_lit(0, 24705, 0, 1'b0);
        // u1: overrun from the tick at 2003, relaunch at tick 3003
        add_lit(1, 2003, 4, 1'b0);
        add_lit(1, 2004, 4, 1'b1);
        add_lit(1, 2005, 4, 1'b0);
        add_lit(1, 3004, 0, 1'b1);
        add_lit(1, 3005, 0, 1'b0);
        // u2: tick 603; data bit 0 and parity of 0x7E, 0x7F, 0x00
        add_lit(2, 621, 0, 1'b0);
        add_lit(2, 733, 0, 1'b0);
        add_lit(2, 798, 0, 1'b1);
        add_lit(2, 910, 0, 1'b1);
        add_lit(2, 950, 0, 1'b1);
        add_lit(2, 975, 0, 1'b0);
        add_lit(2, 1087, 0, 1'b0);
`ifndef UART_BURST_CRLF_EN
        add_lit(0, 9612, 3, 1'b0);
        add_lit(0, 9613, 3, 1'b1);
        add_lit(0, 9614, 1, 1'b0);
        add_lit(0, 26313, 3, 1'b1);
        add_lit(1, 2614, 1, 1'b0);
        add_lit(2, 1134, 3, 1'b1);
`endif
        wait_cyc(4);
        rst_v = 3'b111;
        en_v  = 3'b111;
        // Reset u0 mid-DATA of byte 4 of its second burst
        wait_cyc(16703);
        rst_v[0] = 1'b0;
        wait_cyc(16704);
        rst_v[0] = 1'b1;
        // Drop en during byte 2 of the third burst
        wait_cyc(25100);
        en_v[0] = 1'b0;
        wait_cyc(33000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
